// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants and types for the ram_arbiter block.
//   REQ_FETCH / REQ_LSU / REQ_DBG : requester indices (core fetch, core
//                                   load/store, loader/debug port)
//   arb_state_e                   : ownership state of the arbiter
//   ptr_width()                   : width of a requester index
package ram_arb_pkg;

   localparam int REQ_FETCH = 0;
   localparam int REQ_LSU   = 1;
   localparam int REQ_DBG   = 2;

   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   // Index width for n requesters; never narrower than one bit.
   function automatic int ptr_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester-side bus of ram_arbiter.
//   req/req_addr/req_din/req_bwe/req_lock : per-requester request bundle,
//                                           requester i occupies slice i
//   gnt/rvalid/rdata                      : grant, read-valid and read data
// Modports: master = requester side, slave = arbiter side.
interface ram_arbiter_if #(
   parameter int NREQ       = 3,
   parameter int ADDR_WIDTH = 12
);
   logic [NREQ-1:0]                  req;
   logic [NREQ*(ADDR_WIDTH-2)-1:0]   req_addr;
   logic [NREQ*32-1:0]               req_din;
   logic [NREQ*4-1:0]                req_bwe;
   logic [NREQ-1:0]                  req_lock;
   logic [NREQ-1:0]                  gnt;
   logic [NREQ-1:0]                  rvalid;
   logic [31:0]                      rdata;

   modport master (
      output req, req_addr, req_din, req_bwe, req_lock,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, req_addr, req_din, req_bwe, req_lock,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req  : request vector (NREQ bits)
//   ptr  : index of the last granted requester
//   gnt  : one-hot grant to the first requester after ptr (wrapping), or 0
module rr_pick #(
   parameter int NREQ  = 3,
   parameter int PTR_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt
);

   logic [PTR_W:0]      sh;
   logic [2*NREQ-1:0]   rot_dbl;
   logic [NREQ-1:0]     rot;
   logic [NREQ-1:0]     first;
   logic [NREQ:0]       seen;
   logic [2*NREQ-1:0]   back_dbl;

   // Rotate so the requester right after ptr lands in bit 0.
   assign sh      = (PTR_W+1)'(ptr) + (PTR_W+1)'(1);
   assign rot_dbl = {req, req} >> sh;
   assign rot     = rot_dbl[NREQ-1:0];

   // Lowest set bit of the rotated vector wins.
   assign seen[0] = 1'b0;
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_first
         assign first[gi]    = rot[gi] & ~seen[gi];
         assign seen[gi + 1] = seen[gi] | rot[gi];
      end
   endgenerate

   // Undo the rotation: the upper half of the doubled, left-shifted
   // vector puts the winner back at its original index.
   assign back_dbl = {first, first} << sh;
   assign gnt      = back_dbl[2*NREQ-1:NREQ];

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one ram32 between NREQ requesters.
//   clk, resetn          : clock, asynchronous active-low reset
//   bus (slave modport)  : requester bundle (req, req_addr, req_din, req_bwe,
//                          req_lock in; gnt, rvalid, rdata out)
//   ram_addr/ram_din/ram_bwe/ram_ren out, ram_dout in : ram32 port
// A grant is combinational and issues the access to the RAM in the same
// cycle; read data returns one cycle later with rvalid.
// Optional feature: define RAM_ARB_LOCK_EN to let a requester keep ownership
// across consecutive accesses with req_lock. Without it req_lock is ignored.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NREQ       = 3,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  resetn,
   ram_arbiter_if.slave          bus,
   output logic [ADDR_WIDTH-3:0] ram_addr,
   output logic [31:0]           ram_din,
   output logic [3:0]            ram_bwe,
   output logic                  ram_ren,
   input  logic [31:0]           ram_dout
);

   localparam int AW    = ADDR_WIDTH - 2;
   localparam int PTR_W = ptr_width(NREQ);

   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [NREQ-1:0]  rvalid_q, rvalid_d;
   arb_state_e       state_q, state_d;

   logic [NREQ-1:0]  eligible;
   logic [NREQ-1:0]  pick;
   logic [NREQ-1:0]  gnt_int;
   logic             grant_any;
   logic [PTR_W-1:0] grant_idx;
   logic [AW-1:0]    sel_addr;
   logic [31:0]      sel_din;
   logic [3:0]       sel_bwe;

   logic [AW-1:0]    addr_slice [NREQ];
   logic [31:0]      din_slice  [NREQ];
   logic [3:0]       bwe_slice  [NREQ];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
         assign addr_slice[gi] = bus.req_addr[gi*AW +: AW];
         assign din_slice[gi]  = bus.req_din[gi*32 +: 32];
         assign bwe_slice[gi]  = bus.req_bwe[gi*4 +: 4];
      end
   endgenerate

`ifdef RAM_ARB_LOCK_EN
   logic [PTR_W-1:0] owner_q, owner_d;
   logic [NREQ-1:0]  owner_mask;
   logic             lock_hold;

   // Ownership is released in the same cycle the owner drops req_lock, so
   // the other requesters compete again immediately.
   always_comb begin
      owner_mask          = '0;
      owner_mask[owner_q] = 1'b1;
      lock_hold           = (state_q == ST_LOCKED) && bus.req_lock[owner_q];
      eligible            = lock_hold ? (bus.req & owner_mask) : bus.req;
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{bus.req_lock, state_q};
   assign eligible   = bus.req;
`endif

   rr_pick #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req (eligible),
      .ptr (ptr_q),
      .gnt (pick)
   );

   // Reset is asynchronous, so the combinational grant is gated by it too.
   assign gnt_int   = resetn ? pick : '0;
   assign grant_any = |gnt_int;

   always_comb begin
      sel_addr  = '0;
      sel_din   = '0;
      sel_bwe   = '0;
      grant_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_int[i]) begin
            sel_addr  = addr_slice[i];
            sel_din   = din_slice[i];
            sel_bwe   = bwe_slice[i];
            grant_idx = PTR_W'(i);
         end
      end
   end

   assign ram_addr = sel_addr;
   assign ram_din  = sel_din;
   assign ram_bwe  = sel_bwe;
   assign ram_ren  = grant_any && (sel_bwe == 4'b0000);

   always_comb begin
      rvalid_d = ram_ren ? gnt_int : '0;
      ptr_d    = grant_any ? grant_idx : ptr_q;
      state_d  = ST_OPEN;
`ifdef RAM_ARB_LOCK_EN
      owner_d  = owner_q;
      if (lock_hold) begin
         state_d = ST_LOCKED;
      end else if (grant_any && bus.req_lock[grant_idx]) begin
         state_d = ST_LOCKED;
         owner_d = grant_idx;
      end
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         // Pointer at the last index so requester 0 wins first.
         ptr_q    <= PTR_W'(NREQ - 1);
         rvalid_q <= '0;
         state_q  <= ST_OPEN;
`ifdef RAM_ARB_LOCK_EN
         owner_q  <= '0;
`endif
      end else begin
         ptr_q    <= ptr_d;
         rvalid_q <= rvalid_d;
         state_q  <= state_d;
`ifdef RAM_ARB_LOCK_EN
         owner_q  <= owner_d;
`endif
      end
   end

   assign bus.gnt    = gnt_int;
   assign bus.rvalid = rvalid_q;
   assign bus.rdata  = ram_dout;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3: number of requesters (0 = core fetch, 1 = core load/store, 2 = loader/debug).
REQ-002 SHALL have parameter ADDR_WIDTH, default 12: byte-address width of the shared ram32 instance.
REQ-003 SHALL have port clk  input  1: single clock; all logic on posedge.
REQ-004 SHALL have port resetn  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port req  input  NREQ: request per requester, held high until its gnt.
REQ-006 SHALL have port req_addr  input  NREQ*(ADDR_WIDTH-2): word address, requester i in slice i.
REQ-007 SHALL have port req_din  input  NREQ*32: write data per requester.
REQ-008 SHALL have port req_bwe  input  NREQ*4: byte write enables; all-zero means read.
REQ-009 SHALL have port req_lock  input  NREQ: hold ownership across consecutive accesses (RAM_ARB_LOCK_EN only).
REQ-010 SHALL have port gnt  output  NREQ: one-hot, combinational, the cycle the request is issued to RAM.
REQ-011 SHALL have port rvalid  output  NREQ: one-hot, registered, read data valid for requester.
REQ-012 SHALL have port rdata  output  32: read data, driven from ram_dout.
REQ-013 SHALL have ports ram_addr (ADDR_WIDTH-2), ram_din (32), ram_bwe (4), ram_ren (1) as outputs and ram_dout (32) as input, matching ram32.

Function
REQ-014 SHALL grant at most one requester per cycle, round-robin starting from the index after the last granted one.
REQ-015 SHALL, on grant to i, drive ram_addr/ram_din/ram_bwe from slice i and set ram_ren=1 iff req_bwe slice i is zero.
REQ-016 SHALL, with no grant, drive ram_ren=0 and ram_bwe=0; ram_addr and ram_din are don't-care.
REQ-017 SHALL assert rvalid[i] exactly one cycle after a read grant to i, with rdata = ram_dout that cycle (latency 1).
REQ-018 SHALL treat writes as complete at gnt; no rvalid is produced for writes.
REQ-019 SHALL sustain back-to-back grants every cycle, including read followed by write to the same word (read returns old data).
REQ-020 SHALL update the round-robin pointer to the granted index on every grant; with no grant the pointer holds.
REQ-021 SHALL implement states OPEN and LOCKED; OPEN->LOCKED on grant with req_lock[i]=1, LOCKED->OPEN when owner deasserts req_lock.
REQ-022 SHALL, in LOCKED, grant only the owner; if the owner drops req but keeps lock, grant nobody.
REQ-023 SHALL ignore req bits with no pending request; a requester dropping req before gnt is legal and loses its turn.

Reset
REQ-024 SHALL, while resetn=0, force gnt=0, rvalid=0, ram_ren=0, ram_bwe=0, pointer = NREQ-1 (so requester 0 wins first), state OPEN.
REQ-025 SHALL discard a read in flight when reset asserts mid-operation; no rvalid after reset release.

Configuration
REQ-026 SHALL compile the lock feature only when RAM_ARB_LOCK_EN is defined; without it req_lock is ignored, state is always OPEN, pure round-robin.

Structure
REQ-027 SHALL place requester index constants (REQ_FETCH=0, REQ_LSU=1, REQ_DBG=2) and state encodings in a shared package ram_arb_pkg.
REQ-028 SHALL use one sub-module rr_pick: combinational NREQ-wide round-robin picker (req, pointer -> one-hot grant).

Verification
REQ-029 SHALL cover: req=3'b111 all reads, held 6 cycles after reset -> gnt sequence 001,010,100,001,010,100; each rvalid one cycle after its gnt.
REQ-030 SHALL cover: req1 write addr 0x10, bwe 0011, din 0xAAAA5555, then req0 read addr 0x10 -> rdata low half 0x5555, upper half unchanged.
REQ-031 SHALL cover: read then write same address back-to-back -> read returns pre-write value, next read returns new value.
REQ-032 SHALL cover (RAM_ARB_LOCK_EN): req2 lock for 3 accesses while req0 pending -> gnt=100 three times, then req0 granted next cycle.
REQ-033 SHALL cover: resetn low one cycle after read grant -> rvalid stays 0, gnt=0; after release requester 0 granted first.
